// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU. It grants one operation at a time,
// runs that operation on the ALU for one cycle, and holds the result until the owning
// requester accepts it.
module alu_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_zero,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic        last_grant;
  logic        owner;
  logic [31:0] opd_a;
  logic [31:0] opd_b;
  logic [2:0]  opd_op;
  logic        winner;
  logic        idle;
  logic        grant_fire;
  logic        rsp_fire;

  // The tie-break uses last_grant, so requester 0 wins the first tie after reset.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  assign idle = (state == S_IDLE);

  // Gating with rst_n keeps both readies low while reset is held, even with valid inputs.
  assign req0_ready = rst_n & idle & ~winner & req0_valid;
  assign req1_ready = rst_n & idle & winner & req1_valid;
  assign grant_fire = req0_ready | req1_ready;

  assign rsp0_valid = (state == S_RESP) & ~owner;
  assign rsp1_valid = (state == S_RESP) & owner;
  assign rsp_fire   = owner ? rsp1_ready : rsp0_ready;
  assign busy       = ~idle;

  assign alu_in1  = opd_a;
  assign alu_in2  = opd_b;
  assign alu_ctrl = opd_op;

  // NOTE: the datapath registers are reset along with the control state, so the ALU
  // inputs and rsp_data read as zero right after reset and never carry stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      opd_a      <= '0;
      opd_b      <= '0;
      opd_op     <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      // NOTE: every assignment to sequential state is non-blocking. All registers
      // therefore sample the pre-edge values, and the statement order does not matter.
      case (state)
        S_IDLE: begin
          if (grant_fire) begin
            opd_a  <= winner ? req1_a  : req0_a;
            opd_b  <= winner ? req1_b  : req0_b;
            opd_op <= winner ? req1_op : req0_op;
            owner  <= winner;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data <= alu_result;
          rsp_zero <= (alu_zero != 32'd0);
          state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_fire) begin
            last_grant <= owner;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. It builds one round-robin instance and one fixed-priority
// instance, each driving its own behavioural ALU, and checks every cycle against a
// transaction-level reference model.
module tb_alu_arbiter;

  localparam logic [2:0] ALUOP_ADD = 3'd0;
  localparam logic [2:0] ALUOP_SUB = 3'd1;
  localparam logic [2:0] ALUOP_AND = 3'd2;
  localparam logic [2:0] ALUOP_OR  = 3'd3;
  localparam logic [2:0] ALUOP_XOR = 3'd4;
  localparam logic [2:0] ALUOP_SLT = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Index [i] selects the instance (0 = round-robin, 1 = fixed priority); [k] selects the requester.
  logic        req_valid [2][2];
  logic        req_ready [2][2];
  logic [31:0] req_a     [2][2];
  logic [31:0] req_b     [2][2];
  logic [2:0]  req_op    [2][2];
  logic        rsp_valid [2][2];
  logic        rsp_ready [2][2];
  logic [31:0] alu_in1   [2];
  logic [31:0] alu_in2   [2];
  logic [2:0]  alu_ctrl  [2];
  logic [31:0] alu_result[2];
  logic [31:0] alu_zero  [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_zero  [2];
  logic        busy      [2];

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      ALUOP_AND: return a & b;
      ALUOP_OR:  return a | b;
      ALUOP_XOR: return a ^ b;
      ALUOP_SLT: return {31'd0, $signed(a) < $signed(b)};
      default:   return {a[15:0], b[15:0]} ^ {29'd0, op};
    endcase
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_dut
    assign alu_result[i] = alu_fn(alu_in1[i], alu_in2[i], alu_ctrl[i]);
    assign alu_zero[i]   = (alu_result[i] == 32'd0) ? 32'h0000_0100 : 32'd0;

    alu_arbiter #(.FIXED_PRIO(i)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(req_valid[i][0]),
      .req1_valid(req_valid[i][1]),
      .req0_ready(req_ready[i][0]),
      .req1_ready(req_ready[i][1]),
      .req0_a    (req_a[i][0]),
      .req0_b    (req_b[i][0]),
      .req1_a    (req_a[i][1]),
      .req1_b    (req_b[i][1]),
      .req0_op   (req_op[i][0]),
      .req1_op   (req_op[i][1]),
      .alu_in1   (alu_in1[i]),
      .alu_in2   (alu_in2[i]),
      .alu_ctrl  (alu_ctrl[i]),
      .alu_result(alu_result[i]),
      .alu_zero  (alu_zero[i]),
      .rsp0_valid(rsp_valid[i][0]),
      .rsp1_valid(rsp_valid[i][1]),
      .rsp0_ready(rsp_ready[i][0]),
      .rsp1_ready(rsp_ready[i][1]),
      .rsp_data  (rsp_data[i]),
      .rsp_zero  (rsp_zero[i]),
      .busy      (busy[i])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(int i, string s);
    return $sformatf("i%0d %s", i, s);
  endfunction

  // Reference model: at most one operation is in flight, and it is tracked by its age in cycles.
  bit          m_busy  [2];
  int          m_age   [2];
  int          m_owner [2];
  int          m_last  [2];
  logic [31:0] m_a     [2];
  logic [31:0] m_b     [2];
  logic [2:0]  m_op    [2];
  logic [31:0] m_res   [2];
  bit          m_zero  [2];
  int          obs     [2][$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_age[i] = 0; m_owner[i] = 0; m_last[i] = 1;
      m_a[i] = '0; m_b[i] = '0; m_op[i] = '0; m_res[i] = '0; m_zero[i] = 0;
    end
  endtask

  function automatic int model_winner(int i);
    if (!req_valid[i][0] && !req_valid[i][1]) return -1;
    if (!req_valid[i][1]) return 0;
    if (!req_valid[i][0]) return 1;
    if (i == 1) return 0;
    return 1 - m_last[i];
  endfunction

  // Call at a falling edge with the inputs already applied. The task compares every output
  // and then advances both the model and the clock to the next falling edge.
  task automatic cycle();
    int w [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      w[i] = m_busy[i] ? -1 : model_winner(i);
      check(tg(i, "req0_ready"), req_ready[i][0], w[i] == 0);
      check(tg(i, "req1_ready"), req_ready[i][1], w[i] == 1);
      check(tg(i, "busy"), busy[i], m_busy[i]);
      for (int k = 0; k < 2; k++)
        check(tg(i, $sformatf("rsp%0d_valid", k)), rsp_valid[i][k],
              m_busy[i] && m_age[i] >= 2 && m_owner[i] == k);
      check(tg(i, "rsp_data"), rsp_data[i], m_res[i]);
      check(tg(i, "rsp_zero"), rsp_zero[i], m_zero[i]);
      if (m_busy[i]) begin
        check(tg(i, "alu_in1"), alu_in1[i], m_a[i]);
        check(tg(i, "alu_in2"), alu_in2[i], m_b[i]);
        check(tg(i, "alu_ctrl"), alu_ctrl[i], m_op[i]);
      end
      for (int k = 0; k < 2; k++) if (req_ready[i][k]) obs[i].push_back(k);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!m_busy[i]) begin
        if (w[i] >= 0) begin
          m_busy[i] = 1; m_age[i] = 1; m_owner[i] = w[i];
          m_a[i] = req_a[i][w[i]]; m_b[i] = req_b[i][w[i]]; m_op[i] = req_op[i][w[i]];
        end
      end else if (m_age[i] == 1) begin
        m_age[i]  = 2;
        m_res[i]  = alu_fn(m_a[i], m_b[i], m_op[i]);
        m_zero[i] = (m_res[i] == 32'd0);
      end else if (rsp_ready[i][m_owner[i]]) begin
        m_busy[i] = 0;
        m_last[i] = m_owner[i];
      end else begin
        m_age[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin
        req_valid[i][k] = 0; rsp_ready[i][k] = 0;
        req_a[i][k] = '0; req_b[i][k] = '0; req_op[i][k] = '0;
      end
  endtask

  task automatic set_req(int k, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    for (int i = 0; i < 2; i++) begin
      req_valid[i][k] = 1; req_a[i][k] = a; req_b[i][k] = b; req_op[i][k] = op;
    end
  endtask

  task automatic set_rsp_ready(int k, logic v);
    for (int i = 0; i < 2; i++) rsp_ready[i][k] = v;
  endtask

  // Reset is asserted between clock edges, so every output must drop without waiting for a clock.
  task automatic do_reset();
    rst_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check(tg(i, "rst busy"), busy[i], 0);
      check(tg(i, "rst readies"), {req_ready[i][1], req_ready[i][0]}, 0);
      check(tg(i, "rst rsp valids"), {rsp_valid[i][1], rsp_valid[i][0]}, 0);
      check(tg(i, "rst rsp_data"), rsp_data[i], 0);
      check(tg(i, "rst rsp_zero"), rsp_zero[i], 0);
      check(tg(i, "rst alu_in1"), alu_in1[i], 0);
      check(tg(i, "rst alu_in2"), alu_in2[i], 0);
      check(tg(i, "rst alu_ctrl"), alu_ctrl[i], 0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    #2;
    do_reset();

    // Single add on requester 0; the handshake is in the first cycle after reset is released.
    set_req(0, 32'd5, 32'd3, ALUOP_ADD);
    set_rsp_ready(0, 1);
    cycle();
    idle_inputs();
    set_rsp_ready(0, 1);
    cycle();
    for (int i = 0; i < 2; i++) begin
      check(tg(i, "add rsp0_valid"), rsp_valid[i][0], 1);
      check(tg(i, "add rsp_data"), rsp_data[i], 32'd8);
      check(tg(i, "add rsp_zero"), rsp_zero[i], 0);
    end
    cycle();
    cycle();

    // Operands change right after the handshake; the result must still be 5 + 3.
    set_req(0, 32'd5, 32'd3, ALUOP_ADD);
    set_rsp_ready(0, 1);
    cycle();
    for (int i = 0; i < 2; i++) req_a[i][0] = 32'd9;
    cycle();
    for (int i = 0; i < 2; i++) check(tg(i, "late a rsp_data"), rsp_data[i], 32'd8);
    idle_inputs();
    set_rsp_ready(0, 1);
    cycle();
    cycle();

    // Requester 1 computes 7 - 7 with its response stalled, while requester 0 waits.
    idle_inputs();
    set_req(1, 32'd7, 32'd7, ALUOP_SUB);
    cycle();
    idle_inputs();
    set_req(0, 32'd1, 32'd1, ALUOP_XOR);
    cycle();
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 2; i++) begin
        check(tg(i, "stall rsp1_valid"), rsp_valid[i][1], 1);
        check(tg(i, "stall rsp_data"), rsp_data[i], 0);
        check(tg(i, "stall rsp_zero"), rsp_zero[i], 1);
        check(tg(i, "stall busy"), busy[i], 1);
        check(tg(i, "stall req0_ready"), req_ready[i][0], 0);
      end
      set_rsp_ready(0, 1);
      cycle();
      set_rsp_ready(0, 0);
    end
    set_rsp_ready(1, 1);
    cycle();
    set_rsp_ready(0, 1);
    for (int j = 0; j < 3; j++) cycle();
    idle_inputs();
    cycle();

    // Both requesters valid continuously from reset: the round-robin instance must
    // alternate 0,1,0,1 and the fixed-priority instance must grant 0 every time.
    do_reset();
    for (int i = 0; i < 2; i++) obs[i].delete();
    set_req(0, 32'd10, 32'd4, ALUOP_SUB);
    set_req(1, 32'd6, 32'd3, ALUOP_OR);
    set_rsp_ready(0, 1);
    set_rsp_ready(1, 1);
    for (int j = 0; j < 12; j++) cycle();
    check("i0 grant count", obs[0].size(), 4);
    check("i1 grant count", obs[1].size(), 4);
    for (int j = 0; j < obs[0].size() && j < 4; j++) check($sformatf("i0 grant %0d", j), obs[0][j], j % 2);
    for (int j = 0; j < obs[1].size() && j < 4; j++) check($sformatf("i1 grant %0d", j), obs[1][j], 0);
    idle_inputs();

    // Reset is pulsed during EXEC; the dropped transaction must never produce a response.
    do_reset();
    set_req(0, 32'd1, 32'd2, ALUOP_ADD);
    set_rsp_ready(0, 1);
    cycle();
    do_reset();
    idle_inputs();
    set_rsp_ready(0, 1);
    for (int j = 0; j < 4; j++) begin
      cycle();
      for (int i = 0; i < 2; i++) check(tg(i, "post-rst rsp0_valid"), rsp_valid[i][0], 0);
    end

    // Randomised traffic, including undefined op codes and the occasional reset.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        v;
        logic        r;
        a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        op = 3'($urandom_range(0, 7));
        v  = ($urandom_range(0, 1) == 1);
        r  = ($urandom_range(0, 2) != 0);
        for (int i = 0; i < 2; i++) begin
          req_valid[i][k] = v; req_a[i][k] = a; req_b[i][k] = b; req_op[i][k] = op;
          rsp_ready[i][k] = r;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
